interp_seq_ctrl: RTL and testbench



---
 rtl/chest_interp_pkg.sv | 44 ++++
 rtl/interp_acc.sv | 50 +++++
 rtl/interp_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_interp_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/chest_interp_pkg.sv
// Shared definitions for the channel-estimation interpolation sequencer.
package chest_interp_pkg;

    localparam int unsigned IN_WIDTH_DEF  = 17;
    localparam int unsigned MUX_WIDTH_DEF = 19;
    localparam int unsigned ACC_WIDTH_DEF = 21;

    // Operand-mux select codes (the mux lives outside this block).
    localparam logic [2:0] SEL_E3   = 3'b000;
    localparam logic [2:0] SEL_2E3  = 3'b001;
    localparam logic [2:0] SEL_E4   = 3'b011;
    localparam logic [2:0] SEL_REGE = 3'b010;
    localparam logic [2:0] SEL_ONE  = 3'b110;
    localparam logic [2:0] SEL_4E1  = 3'b100;
    localparam logic [2:0] SEL_ZERO = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A1   = 3'd1,
        ST_A2   = 3'd2,
        ST_A3   = 3'd3,
        ST_A4   = 3'd4,
        ST_B1   = 3'd5,
        ST_B2   = 3'd6,
        ST_B3   = 3'd7
    } state_e;

    // Operand each state asks the mux for.
    function automatic logic [2:0] sel_of_state(input state_e st);
        logic [2:0] sel;
        case (st)
            ST_A1:   sel = SEL_4E1;
            ST_A2:   sel = SEL_2E3;
            ST_A3:   sel = SEL_E3;
            ST_A4:   sel = SEL_E4;
            ST_B1:   sel = SEL_REGE;
            ST_B2:   sel = SEL_E3;
            ST_B3:   sel = SEL_ONE;
            default: sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/interp_acc.sv
// Signed accumulator with clear/load/add and combinational >>>3 / >>>1 taps of acc+operand.
module interp_acc
    import chest_interp_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
    parameter int unsigned MUX_WIDTH = MUX_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        load_i,
    input  logic                        add_i,
    input  logic signed [MUX_WIDTH-1:0] operand_i,
    output logic signed [IN_WIDTH-1:0]  y0_c_o,
    output logic signed [IN_WIDTH-1:0]  y1_c_o
);

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] op_ext;
    logic signed [ACC_WIDTH-1:0] sum_c;

    assign op_ext = ACC_WIDTH'(operand_i);
    assign sum_c  = acc_q + op_ext;
    assign y0_c_o = IN_WIDTH'(sum_c >>> 3);
    assign y1_c_o = IN_WIDTH'(sum_c >>> 1);

    // Next accumulator value; clear has priority over load over add.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = op_ext;
        end else if (add_i) begin
            acc_d = sum_c;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Sequencer for one I or Q rail: y0 = (4E1+3E3+E4)>>>3, y1 = (y0+E3+1)>>>1.
module interp_seq_ctrl
    import chest_interp_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
    parameter int unsigned MUX_WIDTH = MUX_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  E1_in,
    input  logic signed [IN_WIDTH-1:0]  E3_in,
    input  logic signed [IN_WIDTH-1:0]  E4_in,
    output logic signed [IN_WIDTH-1:0]  E1,
    output logic signed [IN_WIDTH-1:0]  E3,
    output logic signed [IN_WIDTH-1:0]  E4,
    output logic signed [IN_WIDTH-1:0]  reg_E,
    output logic [2:0]                  sel_b,
    input  logic signed [MUX_WIDTH-1:0] add2_b,
    output logic signed [IN_WIDTH-1:0]  y_out,
    output logic                        out_valid,
    output logic                        out_idx
);

    state_e                     state_q, state_d;
    logic [2:0]                 sel_q, sel_d;
    logic                       in_ready_q, in_ready_d;
    logic signed [IN_WIDTH-1:0] e1_q, e1_d, e3_q, e3_d, e4_q, e4_d;
    logic signed [IN_WIDTH-1:0] rege_q, rege_d;
    logic signed [IN_WIDTH-1:0] y_q, y_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_idx_q, out_idx_d;
    logic                       acc_clr_c, acc_load_c, acc_add_c;
    logic signed [IN_WIDTH-1:0] y0_c, y1_c;

    interp_acc #(
        .IN_WIDTH  (IN_WIDTH),
        .MUX_WIDTH (MUX_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (acc_clr_c),
        .load_i    (acc_load_c),
        .add_i     (acc_add_c),
        .operand_i (add2_b),
        .y0_c_o    (y0_c),
        .y1_c_o    (y1_c)
    );

    // Next-state, accumulator control and registered-output next values.
    always_comb begin
        state_d     = state_q;
        e1_d        = e1_q;
        e3_d        = e3_q;
        e4_d        = e4_q;
        rege_d      = rege_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        acc_clr_c   = 1'b0;
        acc_load_c  = 1'b0;
        acc_add_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    e1_d      = E1_in;
                    e3_d      = E3_in;
                    e4_d      = E4_in;
                    acc_clr_c = 1'b1;
                    state_d   = ST_A1;
                end
            end
            ST_A1: begin
                acc_add_c = 1'b1;
                state_d   = ST_A2;
            end
            ST_A2: begin
                acc_add_c = 1'b1;
                state_d   = ST_A3;
            end
            ST_A3: begin
                acc_add_c = 1'b1;
                state_d   = ST_A4;
            end
            ST_A4: begin
                y_d         = y0_c;
                rege_d      = y0_c;
                out_valid_d = 1'b1;
                out_idx_d   = 1'b0;
                acc_clr_c   = 1'b1;
                state_d     = ST_B1;
            end
            ST_B1: begin
                acc_load_c = 1'b1;
                state_d    = ST_B2;
            end
            ST_B2: begin
                acc_add_c = 1'b1;
                state_d   = ST_B3;
            end
            ST_B3: begin
                y_d         = y1_c;
                out_valid_d = 1'b1;
                out_idx_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sel_d      = sel_of_state(state_d);
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_ZERO;
            in_ready_q  <= 1'b1;
            e1_q        <= '0;
            e3_q        <= '0;
            e4_q        <= '0;
            rege_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            in_ready_q  <= in_ready_d;
            e1_q        <= e1_d;
            e3_q        <= e3_d;
            e4_q        <= e4_d;
            rege_q      <= rege_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign sel_b     = sel_q;
    assign E1        = e1_q;
    assign E3        = e3_q;
    assign E4        = e4_q;
    assign reg_E     = rege_q;
    assign y_out     = y_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Directed bench for interp_seq_ctrl with an external operand-mux model and a per-set behavioural model.
module tb_interp_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [16:0] E1_in = '0, E3_in = '0, E4_in = '0;
    logic signed [16:0] E1, E3, E4, reg_E, y_out;
    logic [2:0]         sel_b;
    logic signed [18:0] add2_b;
    logic               out_valid, out_idx;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    interp_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .E1_in     (E1_in),
        .E3_in     (E3_in),
        .E4_in     (E4_in),
        .E1        (E1),
        .E3        (E3),
        .E4        (E4),
        .reg_E     (reg_E),
        .sel_b     (sel_b),
        .add2_b    (add2_b),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_idx   (out_idx)
    );

    // Operand mux that sits beside the block in the real datapath.
    always_comb begin
        case (sel_b)
            3'b100:  add2_b = 19'(E1) <<< 2;
            3'b001:  add2_b = 19'(E3) <<< 1;
            3'b000:  add2_b = 19'(E3);
            3'b011:  add2_b = 19'(E4);
            3'b010:  add2_b = 19'(reg_E);
            3'b110:  add2_b = 19'sd1;
            default: add2_b = '0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a set is 8 cycles; phase 0 is idle, phases 1..7 busy.
    int phase = 0;
    int m_e1 = 0, m_e3 = 0, m_e4 = 0, m_rege = 0, m_y = 0, m_idx = 0, m_valid = 0;
    int sel_tab [8] = '{7, 4, 1, 0, 3, 2, 0, 6};
    bit started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            phase <= 0; m_e1 <= 0; m_e3 <= 0; m_e4 <= 0;
            m_rege <= 0; m_y <= 0; m_idx <= 0; m_valid <= 0;
        end else begin
            m_valid <= 0;
            if (phase == 0) begin
                if (in_valid) begin
                    m_e1 <= int'(E1_in); m_e3 <= int'(E3_in); m_e4 <= int'(E4_in);
                    phase <= 1;
                end
            end else if (phase == 4) begin
                m_y     <= (4 * m_e1 + 3 * m_e3 + m_e4) >>> 3;
                m_rege  <= (4 * m_e1 + 3 * m_e3 + m_e4) >>> 3;
                m_valid <= 1; m_idx <= 0; phase <= 5;
            end else if (phase == 7) begin
                m_y     <= (m_rege + m_e3 + 1) >>> 1;
                m_valid <= 1; m_idx <= 1; phase <= 0;
            end else begin
                phase <= phase + 1;
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",  int'(in_ready),  (phase == 0) ? 1 : 0);
            chk("sel_b",     int'(sel_b),     sel_tab[phase]);
            chk("out_valid", int'(out_valid), m_valid);
            chk("out_idx",   int'(out_idx),   m_idx);
            chk("y_out",     int'(y_out),     m_y);
            chk("reg_E",     int'(reg_E),     m_rege);
            chk("E1",        int'(E1),        m_e1);
            chk("E3",        int'(E3),        m_e3);
            chk("E4",        int'(E4),        m_e4);
        end
    end

    // One set from an idle cycle; fixed latency y0 at T+5, y1 at T+8.
    task automatic run_set(input int e1, input int e3, input int e4,
                           input int y0, input int y1, input bit chk_sel);
        logic [2:0] seq [7];
        logic [2:0] exp_sel [7];
        exp_sel = '{3'b100, 3'b001, 3'b000, 3'b011, 3'b010, 3'b000, 3'b110};
        @(posedge clk); #1;
        E1_in = 17'(e1); E3_in = 17'(e3); E4_in = 17'(e4); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            seq[i] = sel_b;
            if (i == 4) begin
                chk("y0_valid", int'(out_valid), 1);
                chk("y0_value", int'(y_out), y0);
                chk("y0_idx",   int'(out_idx), 0);
            end
        end
        @(negedge clk);
        chk("y1_valid", int'(out_valid), 1);
        chk("y1_value", int'(y_out), y1);
        chk("y1_idx",   int'(out_idx), 1);
        if (chk_sel) begin
            for (int i = 0; i < 7; i++) chk("sel_seq", int'(seq[i]), int'(exp_sel[i]));
        end
    endtask

    initial begin
        int acc_cnt;
        int acc_pos [$];
        int vcnt;
        int y_hold;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_sel_b",     int'(sel_b), 7);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y_out",     int'(y_out), 0);
        chk("rst_reg_E",     int'(reg_E), 0);

        run_set(100, 40, -8, 64, 52, 1'b1);
        run_set(-100, -40, 8, -64, -52, 1'b0);
        run_set(-65536, -65536, -65536, -65536, -65536, 1'b0);
        run_set(65535, 65535, 65535, 65535, 65535, 1'b0);

        // Continuous in_valid with fresh values every cycle.
        acc_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            E1_in = 17'(10 * k + 3); E3_in = 17'(-7 * k); E4_in = 17'(k * k - 50);
            @(negedge clk);
            if (in_ready) begin
                acc_cnt++;
                acc_pos.push_back(k);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stream_accepts", acc_cnt, 2);
        if (acc_pos.size() == 2) begin
            chk("stream_first", acc_pos[0], 0);
            chk("stream_second", acc_pos[1], 8);
        end else begin
            chk("stream_pos_count", acc_pos.size(), 2);
        end
        repeat (10) @(posedge clk);

        // Reset in the middle of a set: no output for it.
        @(posedge clk); #1;
        E1_in = 17'(500); E3_in = 17'(300); E4_in = 17'(-20); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("rst_mid_no_valid", vcnt, 0);
        chk("rst_mid_ready", int'(in_ready), 1);
        chk("rst_mid_y_out", int'(y_out), 0);
        run_set(100, 40, -8, 64, 52, 1'b1);

        // Long idle stretch.
        y_hold = int'(y_out);
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid || sel_b != 3'b111 || int'(y_out) != y_hold) vcnt++;
        end
        chk("idle_stable", vcnt, 0);
        chk("idle_y_out", int'(y_out), 52);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
